pipeline_sink: RTL and testbench
================================

Name: pipeline_sink

Overview:
- Terminal consumer for the valid/stall/flush pipeline stream; it sits at the downstream end of a chain of pipeline stages.
- Drives the stall signal back upstream and accepts words into a small show-ahead FIFO that a host/test harness drains.
- Stalls on a programmable rotating pattern, so upstream skid buffers can be exercised under controlled backpressure.
- Counts accepted words, keeps a running sum checksum, and signals done once a programmed word count has been accepted.

Parameters:
- WIDTH, 32, data word width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PAT_W, 8, stall pattern length in cycles.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  data word from the last pipeline stage.
- in_valid  input  1  in_data holds a valid word.
- in_flush  input  1  flush marker from upstream.
- out_stall  output  1  backpressure to upstream; the word is held while asserted.
- start  input  1  one-cycle pulse that arms a run.
- target_count  input  16  number of words to accept per run; sampled on start.
- stall_pattern  input  PAT_W  bit i = 1 means stall in pattern phase i; sampled on start.
- rd_en  input  1  host pops the FIFO head.
- rd_data  output  WIDTH  FIFO head (show-ahead).
- rd_valid  output  1  FIFO non-empty.
- word_count  output  16  words accepted in the current run.
- checksum  output  WIDTH  sum of accepted words, modulo 2^WIDTH.
- flush_count  output  8  flushes observed, saturating at 255.
- done  output  1  high while in DONE.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE.
  - FIFO empty; rd_valid = 0, rd_data = 0.
  - word_count = 0, checksum = 0, flush_count = 0, done = 0.
  - Pattern pointer = 0.
  - out_stall = 1.
- Reset mid-run discards all state, including FIFO contents.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE, start = 1:
    - Latch target_count and stall_pattern.
    - Clear word_count and checksum; pointer = 0.
    - Go to RUN, or to DONE if target_count == 0.
    - FIFO contents are untouched.
  - RUN, start = 1: ignored.
  - RUN -> DONE in the cycle after the accept that makes word_count == target.
- out_stall is combinational from registers only, with no path from in_valid:
  - out_stall = (state != RUN) | fifo_full | pat_q[ptr].
- Accept condition: in_valid & !out_stall & !in_flush.
  - Write in_data into the FIFO.
  - word_count += 1.
  - checksum += in_data (wraps).
  - Latency: rd_valid rises the cycle after the accept.
- Pointer advances every cycle in RUN regardless of in_valid, wrapping PAT_W-1 -> 0. It is frozen in IDLE and DONE.
- in_flush = 1:
  - FIFO cleared at the clock edge.
  - flush_count += 1, saturating at 255.
  - Any in_valid in that cycle is not accepted.
  - rd_en in that cycle is ignored.
  - word_count, checksum and state are unchanged.
- FIFO behaviour:
  - Pop on rd_en & rd_valid. rd_en while empty is ignored.
  - Push and pop in the same cycle: occupancy unchanged, pointers both advance with wrap at DEPTH.
  - Push while full cannot occur, because full forces out_stall.
  - A pop in a full cycle deasserts full the next cycle; accept resumes then, since there is no same-cycle bypass.
- An all-ones stall_pattern stalls permanently; the run never completes until reset.
- done = (state == DONE).

Test Plan:
- Reset, then start with target=3, pattern=0x00; drive 0x10, 0x20, 0x30 with in_valid continuously and rd_en=1 -> three accepts in 3 consecutive cycles, word_count=3, checksum=0x60, done the cycle after the third accept, out_stall=1 afterwards.
- Pattern=0x0A, target=8, in_valid held with an incrementing source that advances only when !out_stall -> out_stall high in phases 1 and 3 of each 8-cycle window; 8 words accepted in order 1..8; checksum=36.
- DEPTH=4, rd_en=0, target=10, pattern=0 -> 4 accepts, then out_stall=1 (full); single rd_en pop -> one more accept the next cycle; rd_data order preserved.
- 2 words in FIFO, then in_flush=1 with in_valid=1 and rd_en=1 in the same cycle -> FIFO empty next cycle, rd_valid=0, flush_count=1, word_count unchanged, flushed-cycle word not counted.
- start with target=0 -> done the next cycle, out_stall stays 1; start while RUN is ignored (word_count is not cleared).
- Checksum wrap: accept 0xFFFFFFFF then 0x00000002 -> checksum=0x00000001. Reset asserted mid-run -> all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/pipeline_sink.sv
// pipeline_sink: terminal consumer for a valid/stall/flush pipeline stream.
// Accepted words land in a small show-ahead FIFO that a host drains. The
// block stalls upstream on a programmable rotating pattern, counts accepted
// words, keeps a wrapping sum checksum, and reports done once the
// programmed word count has been accepted.
`timescale 1ns/1ps

module pipeline_sink #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,     // power of two, >= 2
    parameter int PAT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_flush,
    output logic             out_stall,
    input  logic             start,
    input  logic [15:0]      target_count,
    input  logic [PAT_W-1:0] stall_pattern,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [15:0]      word_count,
    output logic [WIDTH-1:0] checksum,
    output logic [7:0]       flush_count,
    output logic             done
);

    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [AW:0]      FULL_FILL = (AW+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [15:0]      tgt_q;
    logic [PAT_W-1:0] pat_q;
    logic [PTR_W-1:0] ptr;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      fill;

    logic fifo_full;
    logic accept;
    logic pop;

    // Stall depends only on registered state, so there is no combinational
    // path from in_valid back to out_stall.
    assign fifo_full = (fill == FULL_FILL);
    assign out_stall = (state != RUN) | fifo_full | pat_q[ptr];
    assign accept    = in_valid & ~out_stall & ~in_flush;
    // A flush overrides the host read in the same cycle.
    assign pop       = rd_en & rd_valid & ~in_flush;

    assign rd_valid  = (fill != '0);
    // Show-ahead head; forced to zero when empty so stale entries never leak.
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;
    assign done      = (state == DONE);

    // Run control: FSM, pattern pointer, word count, checksum, flush counter.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            tgt_q       <= '0;
            pat_q       <= '0;
            ptr         <= '0;
            word_count  <= '0;
            checksum    <= '0;
            flush_count <= '0;
        end else begin
            if (in_flush && flush_count != 8'hFF)
                flush_count <= flush_count + 8'd1;

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        tgt_q      <= target_count;
                        pat_q      <= stall_pattern;
                        word_count <= '0;
                        checksum   <= '0;
                        ptr        <= '0;
                        state      <= (target_count == 16'd0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
                    if (accept) begin
                        word_count <= word_count + 16'd1;
                        checksum   <= checksum + in_data;
                        // Leave RUN on the final accept so no extra word slips in.
                        if (word_count + 16'd1 == tgt_q)
                            state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; a flush empties the FIFO at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (in_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            case ({accept, pop})
                2'b10:   fill <= fill + (AW+1)'(1);
                2'b01:   fill <= fill - (AW+1)'(1);
                default: fill <= fill;
            endcase
        end
    end

    // FIFO storage writes.
    // NOTE: the storage array is deliberately not reset; occupancy and the
    // rd_data mask make its contents unobservable until written.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= in_data;
    end

endmodule

// File: tb/tb_pipeline_sink.sv
// Self-checking bench for pipeline_sink: directed stimulus pushes expected
// FIFO words into a scoreboard queue; a monitor pops and compares on every
// host read. Status outputs are checked against hand-computed values.
`timescale 1ns/1ps

module tb_pipeline_sink;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_flush;
    logic        out_stall;
    logic        start;
    logic [15:0] target_count;
    logic [7:0]  stall_pattern;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [15:0] word_count;
    logic [31:0] checksum;
    logic [7:0]  flush_count;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    pipeline_sink #(.WIDTH(32), .DEPTH(4), .PAT_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_flush     (in_flush),
        .out_stall    (out_stall),
        .start        (start),
        .target_count (target_count),
        .stall_pattern(stall_pattern),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .word_count   (word_count),
        .checksum     (checksum),
        .flush_count  (flush_count),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] tgt, input logic [7:0] pat);
        start         = 1'b1;
        target_count  = tgt;
        stall_pattern = pat;
        tick();
        start         = 1'b0;
    endtask

    // Monitor: every host read that the DUT will honour pops one expected word.
    always @(negedge clk) begin
        if (!reset && rd_en && rd_valid && !in_flush) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rd", {32'd0, rd_data}, 64'hDEAD_BEEF_DEAD_BEEF);
            end else begin
                check("rd_data", {32'd0, rd_data}, {32'd0, exp_q.pop_front()});
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: timeout expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  pat;
        logic [31:0] nxt;
        logic        exp_stall;
        int          acc;

        reset = 1'b1; in_data = '0; in_valid = 1'b0; in_flush = 1'b0;
        start = 1'b0; target_count = '0; stall_pattern = '0; rd_en = 1'b0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_stall",  out_stall,   1);
        check("rst_rdv",    rd_valid,    0);
        check("rst_rdd",    rd_data,     0);
        check("rst_wc",     word_count,  0);
        check("rst_cs",     checksum,    0);
        check("rst_fc",     flush_count, 0);
        check("rst_done",   done,        0);

        // Three back-to-back accepts, no stall pattern
        rd_en = 1'b1;
        do_start(16'd3, 8'h00);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h10 * (i + 1);
            check("t1_stall", out_stall, 0);
            exp_q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        check("t1_wc",    word_count, 3);
        check("t1_cs",    checksum,   32'h60);
        check("t1_done",  done,       1);
        check("t1_stall_after", out_stall, 1);
        tick(); tick();
        check("t1_drained", rd_valid, 0);

        // Rotating stall pattern 0x0A: stall in phases 1 and 3
        pat = 8'h0A;
        do_start(16'd8, pat);
        nxt = 32'd1;
        acc = 0;
        for (int cyc = 0; cyc < 40 && acc < 8; cyc++) begin
            exp_stall = pat[cyc % 8];
            in_valid  = 1'b1;
            in_data   = nxt;
            check("t2_stall_phase", out_stall, exp_stall);
            if (!exp_stall) begin
                exp_q.push_back(nxt);
                nxt++;
                acc++;
            end
            tick();
        end
        in_valid = 1'b0;
        check("t2_wc",   word_count, 8);
        check("t2_cs",   checksum,   36);
        check("t2_done", done,       1);
        tick(); tick();

        // FIFO full backpressure with no host reads
        rd_en = 1'b0;
        do_start(16'd10, 8'h00);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + i;
            check("t3_stall_fill", out_stall, 0);
            exp_q.push_back(in_data);
            tick();
        end
        in_data = 32'hA4;
        check("t3_full_stall", out_stall, 1);
        check("t3_rdv",        rd_valid,  1);
        tick();
        check("t3_wc_held", word_count, 4);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("t3_resume", out_stall, 0);
        exp_q.push_back(32'hA4);
        tick();
        in_valid = 1'b0;
        check("t3_wc5",       word_count, 5);
        check("t3_full_again", out_stall, 1);
        rd_en = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rd_en = 1'b0;
        check("t3_drained", rd_valid, 0);

        // Flush with two words queued, plus in_valid and rd_en in the flush cycle
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hB0 + i;
            check("t4_stall", out_stall, 0);
            tick();
        end
        check("t4_rdv_pre", rd_valid, 1);
        in_flush = 1'b1; in_valid = 1'b1; in_data = 32'hBB; rd_en = 1'b1;
        exp_q.delete();
        tick();
        in_flush = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
        check("t4_rdv", rd_valid,    0);
        check("t4_rdd", rd_data,     0);
        check("t4_fc",  flush_count, 1);
        check("t4_wc",  word_count,  7);

        // Start while running is ignored
        start = 1'b1; target_count = 16'd2; stall_pattern = 8'hFF;
        tick();
        start = 1'b0;
        check("t5_wc_kept",  word_count, 7);
        check("t5_not_done", done,       0);
        check("t5_run",      out_stall,  0);

        // Reset mid-run discards everything, FIFO included
        in_valid = 1'b1; in_data = 32'hC0;
        tick();
        in_valid = 1'b0;
        check("t6_rdv_pre", rd_valid, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rdv",   rd_valid,    0);
        check("t6_rdd",   rd_data,     0);
        check("t6_wc",    word_count,  0);
        check("t6_cs",    checksum,    0);
        check("t6_fc",    flush_count, 0);
        check("t6_done",  done,        0);
        check("t6_stall", out_stall,   1);

        // Zero target goes straight to DONE
        do_start(16'd0, 8'h00);
        check("t7_done",  done,      1);
        check("t7_stall", out_stall, 1);
        tick();
        check("t7_stall_hold", out_stall, 1);

        // Checksum wrap
        rd_en = 1'b1;
        do_start(16'd2, 8'h00);
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        exp_q.push_back(in_data);
        tick();
        in_data = 32'h0000_0002;
        exp_q.push_back(in_data);
        tick();
        in_valid = 1'b0;
        check("t8_cs",   checksum, 32'h1);
        check("t8_done", done,     1);
        for (int i = 0; i < 3; i++) tick();

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
